// File: rtl/feed_scheduler_pkg.sv
// Shared types and width helpers for the operand feed scheduler.
// Counter widths derive from array size and FIFO depth.
package feed_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_FEED,
    S_DONE
  } state_t;

  localparam int STATE_W = 3;

  function automatic int load_cnt_w(input int as, input int fd);
    return $clog2(2 * as * fd + 1);
  endfunction

  function automatic int skew_cnt_w(input int as, input int fd);
    return $clog2(fd + as);
  endfunction

  localparam int LOAD_CNT_W = load_cnt_w(2, 8);
  localparam int SKEW_CNT_W = skew_cnt_w(2, 8);

endpackage

// File: rtl/skew_rd_gen.sv
// Skewed per-row FIFO read enables: row i reads during t in [i, i+len).
// compute_valid follows any read by one cycle (FIFO read latency).
module skew_rd_gen
  import feed_scheduler_pkg::*;
#(
  parameter int ARRAY_SIZE = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [3:0]            tile_len,
  output logic [ARRAY_SIZE-1:0] rd_en,
  output logic                  compute_valid,
  output logic                  last
);

  localparam int SW = skew_cnt_w(ARRAY_SIZE, FIFO_DEPTH);

  logic [SW-1:0] t_q;

  assign last = en &&
    (int'(t_q) == int'(tile_len) + ARRAY_SIZE - 2);

  always_ff @(posedge clk) begin
    if (!rst_n || !en || last) begin
      t_q <= '0;
    end else begin
      t_q <= t_q + SW'(1);
    end
  end

  always_comb begin
    rd_en = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      rd_en[i] = en && (int'(t_q) >= i) &&
        (int'(t_q) < i + int'(tile_len));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      compute_valid <= 1'b0;
    end else begin
      compute_valid <= |rd_en;
    end
  end

endmodule

// File: rtl/feed_scheduler.sv
// Tile load/feed sequencer for the systolic operand queues.
// Streams SRAM into row FIFOs, then issues skewed row reads.
module feed_scheduler
  import feed_scheduler_pkg::*;
#(
  parameter int ARRAY_SIZE = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [3:0]              tile_len,
  output logic                    sram_rd_en,
  output logic [ADDR_W-1:0]       sram_addr,
  input  logic [2*ARRAY_SIZE-1:0] fifo_full,
  output logic [2*ARRAY_SIZE-1:0] fifo_wr_en,
  output logic [ARRAY_SIZE-1:0]   fifo_rd_en,
  output logic                    compute_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int NQ  = 2 * ARRAY_SIZE;
  localparam int LCW = load_cnt_w(ARRAY_SIZE, FIFO_DEPTH);
  localparam int QW  = (NQ > 1) ? $clog2(NQ) : 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [3:0]        len_q;
  logic [LCW-1:0]    k_q;
  logic [3:0]        e_q;
  logic [QW-1:0]     q_q;
  logic [QW-1:0]     wr_q_q;
  logic              wr_pend_q;
  logic              err_q;

  logic              idle;
  logic              start_ok;
  logic              start_zero;
  logic              start_bad;
  logic              load_last;
  logic              feed_last;
  logic              wr_hit_full;
  logic [NQ-1:0]     wr_onehot;

  assign idle       = (state_q == S_IDLE);
  assign start_ok   = idle && start && (tile_len != 4'd0) &&
                      (int'(tile_len) <= FIFO_DEPTH);
  assign start_zero = idle && start && (tile_len == 4'd0);
  assign start_bad  = idle && start &&
                      (int'(tile_len) > FIFO_DEPTH);
  assign load_last  = (int'(k_q) == NQ * int'(len_q) - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          start_ok:   state_d = S_LOAD;
          start_zero: state_d = S_DONE;
          default:    state_d = S_IDLE;
        endcase
      end
      S_LOAD:  if (load_last) state_d = S_DRAIN;
      S_DRAIN: state_d = S_FEED;
      S_FEED:  if (feed_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A read issued in LOAD becomes a queue write one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q    <= '0;
      len_q     <= '0;
      k_q       <= '0;
      e_q       <= '0;
      q_q       <= '0;
      wr_q_q    <= '0;
      wr_pend_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_pend_q <= (state_q == S_LOAD);
      wr_q_q    <= q_q;
      if (start_ok) begin
        base_q <= base_addr;
        len_q  <= tile_len;
        k_q    <= '0;
        e_q    <= '0;
        q_q    <= '0;
      end else if (state_q == S_LOAD) begin
        k_q <= k_q + LCW'(1);
        if (e_q == len_q - 4'd1) begin
          e_q <= '0;
          q_q <= q_q + QW'(1);
        end else begin
          e_q <= e_q + 4'd1;
        end
      end
      if (start_bad) begin
        err_q <= 1'b1;
      end else if (start_ok || start_zero) begin
        err_q <= 1'b0;
      end else if (wr_hit_full) begin
        err_q <= 1'b1;
      end
    end
  end

  assign wr_onehot   = NQ'(1) << wr_q_q;
  assign wr_hit_full = wr_pend_q && |(wr_onehot & fifo_full);
  assign fifo_wr_en  = wr_pend_q ? (wr_onehot & ~fifo_full) : '0;

  assign sram_rd_en = (state_q == S_LOAD);
  assign sram_addr  = sram_rd_en ? base_q + ADDR_W'(k_q) : '0;
  assign busy       = !idle;
  assign done       = (state_q == S_DONE);
  assign err        = err_q;

  skew_rd_gen #(
    .ARRAY_SIZE(ARRAY_SIZE),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_skew (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (state_q == S_FEED),
    .tile_len     (len_q),
    .rd_en        (fifo_rd_en),
    .compute_valid(compute_valid),
    .last         (feed_last)
  );

endmodule

// File: tb/tb_feed_scheduler.sv
// Bench for feed_scheduler: job-timeline model checked every cycle,
// plus literal timing pins for each directed scenario.
module tb_feed_scheduler;

  localparam int AS = 2;
  localparam int FD = 8;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [3:0]    tile_len = '0;
  logic          sram_rd_en;
  logic [AW-1:0] sram_addr;
  logic [3:0]    fifo_full = '0;
  logic [3:0]    fifo_wr_en;
  logic [1:0]    fifo_rd_en;
  logic          compute_valid;
  logic          busy;
  logic          done;
  logic          err;

  feed_scheduler #(
    .ARRAY_SIZE(AS),
    .FIFO_DEPTH(FD),
    .ADDR_W    (AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .tile_len     (tile_len),
    .sram_rd_en   (sram_rd_en),
    .sram_addr    (sram_addr),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_rd_en   (fifo_rd_en),
    .compute_valid(compute_valid),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_on = 0;

  // job model: one outstanding tile, timeline relative to accept cycle
  bit m_active = 0;
  bit m_err = 0;
  int jt0 = 0;
  int jlen = 0;
  int jbase = 0;

  // observation logs
  int addr_log[$];
  bit done_seen;
  int done_cnt, done_r, wr2_cnt, wr3_first;
  int rd0_first, rd1_first, cv_first, cv_last;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    addr_log.delete();
    done_seen = 0;
    done_cnt = 0;
    done_r = -1;
    wr2_cnt = 0;
    wr3_first = -1;
    rd0_first = -1;
    rd1_first = -1;
    cv_first = -1;
    cv_last = -1;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_active = 0;
      m_err = 0;
    end else if (m_active) begin
      int r, n, d;
      r = cyc - jt0;
      n = 2 * AS * jlen;
      d = (jlen == 0) ? 1 : n + jlen + AS + 1;
      if (jlen != 0 && r >= 2 && r <= n + 1 &&
          fifo_full[(r - 2) / jlen])
        m_err = 1;
      if (r == d) m_active = 0;
    end else if (start) begin
      if (int'(tile_len) > FD) begin
        m_err = 1;
      end else begin
        m_err = 0;
        m_active = 1;
        jt0 = cyc;
        jlen = int'(tile_len);
        jbase = int'(base_addr);
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      int r, n, d, t, q;
      int e_rd, e_addr, e_wr, e_rden, e_cv, e_busy, e_done;
      e_rd = 0; e_addr = 0; e_wr = 0; e_rden = 0;
      e_cv = 0; e_busy = 0; e_done = 0;
      r = cyc - jt0;
      if (m_active) begin
        if (jlen == 0) begin
          e_busy = (r == 1) ? 1 : 0;
          e_done = e_busy;
        end else begin
          n = 2 * AS * jlen;
          d = n + jlen + AS + 1;
          e_busy = (r >= 1 && r <= d) ? 1 : 0;
          e_done = (r == d) ? 1 : 0;
          if (r >= 1 && r <= n) begin
            e_rd = 1;
            e_addr = (jbase + r - 1) % (1 << AW);
          end
          if (r >= 2 && r <= n + 1) begin
            q = (r - 2) / jlen;
            if (!fifo_full[q]) e_wr = 1 << q;
          end
          t = r - (n + 2);
          for (int i = 0; i < AS; i++)
            if (t >= i && t < i + jlen) e_rden |= 1 << i;
          e_cv = (r >= n + 3 && r <= n + jlen + AS + 1) ? 1 : 0;
        end
      end
      chk("sram_rd_en", int'(sram_rd_en), e_rd);
      chk("sram_addr", int'(sram_addr), e_addr);
      chk("fifo_wr_en", int'(fifo_wr_en), e_wr);
      chk("fifo_rd_en", int'(fifo_rd_en), e_rden);
      chk("compute_valid", int'(compute_valid), e_cv);
      chk("busy", int'(busy), e_busy);
      chk("done", int'(done), e_done);
      chk("err", int'(err), int'(m_err));
      if (sram_rd_en) addr_log.push_back(int'(sram_addr));
      if (done) begin
        done_seen = 1;
        done_cnt++;
        done_r = r;
      end
      if (fifo_wr_en[2]) wr2_cnt++;
      if (fifo_wr_en[3] && wr3_first < 0) wr3_first = r;
      if (fifo_rd_en[0] && rd0_first < 0) rd0_first = r;
      if (fifo_rd_en[1] && rd1_first < 0) rd1_first = r;
      if (compute_valid) begin
        if (cv_first < 0) cv_first = r;
        cv_last = r;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic go(input int b, input int l);
    clear_logs();
    base_addr = AW'(b);
    tile_len = 4'(l);
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      if (done_seen) break;
      step(1);
    end
    if (!done_seen) chk("done_timeout", 0, 1);
    step(2);
  endtask

  initial begin
    clear_logs();
    step(3);
    chk("reset_busy", int'(busy), 0);
    chk("reset_rd", int'(sram_rd_en), 0);
    chk("reset_wr", int'(fifo_wr_en), 0);
    chk("reset_err", int'(err), 0);
    rst_n = 1'b1;
    chk_on = 1;
    step(2);

    // full tile, len 8
    go(32'h100, 8);
    wait_done();
    chk("t1_nreads", addr_log.size(), 32);
    chk("t1_addr_first", addr_log[0], 32'h100);
    chk("t1_addr_last", addr_log[31], 32'h11F);
    chk("t1_wr3_first", wr3_first, 26);
    chk("t1_rd0_first", rd0_first, 34);
    chk("t1_rd1_first", rd1_first, 35);
    chk("t1_cv_first", cv_first, 35);
    chk("t1_cv_last", cv_last, 43);
    chk("t1_done", done_r, 43);

    // address wrap, len 1
    go(32'h3FE, 1);
    wait_done();
    chk("t2_nreads", addr_log.size(), 4);
    chk("t2_a0", addr_log[0], 32'h3FE);
    chk("t2_a1", addr_log[1], 32'h3FF);
    chk("t2_a2", addr_log[2], 32'h000);
    chk("t2_a3", addr_log[3], 32'h001);
    chk("t2_rd0", rd0_first, 6);
    chk("t2_rd1", rd1_first, 7);
    chk("t2_done", done_r, 8);

    // zero-length tile
    go(32'h050, 0);
    wait_done();
    chk("t3_done", done_r, 1);
    chk("t3_nreads", addr_log.size(), 0);
    chk("t3_rd0", rd0_first, -1);

    // oversize tile
    go(32'h050, 9);
    step(3);
    chk("t4_busy", int'(busy), 0);
    chk("t4_err", int'(err), 1);
    chk("t4_nreads", addr_log.size(), 0);

    // queue 2 full throughout
    fifo_full = 4'b0100;
    go(32'h200, 4);
    wait_done();
    fifo_full = 4'b0000;
    chk("t5_wr2", wr2_cnt, 0);
    chk("t5_err", int'(err), 1);
    chk("t5_done", done_r, 23);

    // start pulse during LOAD is ignored
    go(32'h100, 8);
    step(4);
    tile_len = 4'd3;
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_done();
    step(5);
    chk("t6_done_cnt", done_cnt, 1);
    chk("t6_done", done_r, 43);
    chk("t6_err", int'(err), 0);

    // reset during second FEED cycle
    go(32'h100, 8);
    for (int i = 0; i < 100; i++) begin
      if (cyc == jt0 + 35) break;
      step(1);
    end
    chk("t7_in_feed", int'(fifo_rd_en), 3);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("t7_busy", int'(busy), 0);
    chk("t7_rd_en", int'(fifo_rd_en), 0);
    chk("t7_cv", int'(compute_valid), 0);
    chk("t7_wr", int'(fifo_wr_en), 0);
    chk("t7_done_cnt", done_cnt, 0);
    step(2);

    // normal operation after reset
    go(32'h020, 2);
    wait_done();
    chk("t8_nreads", addr_log.size(), 8);
    chk("t8_addr_last", addr_log[7], 32'h027);
    chk("t8_done", done_r, 13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
